// File: rtl/sdr_sched_pkg.sv
// Shared types and defaults for the SDRAM access scheduler.
package sdr_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REF_REQ,
    S_REF_WAIT,
    S_ACC_START,
    S_ACC_WAIT
  } sched_state_t;

  localparam int DEFAULT_REF_PERIOD = 780;

endpackage

// File: rtl/sdr_rr_arbiter.sv
// Combinational round-robin picker: the first set request after ptr wins,
// wrapping around, so ptr itself has the lowest priority.
module sdr_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/sdr_access_sched.sv
// Front-end scheduler for the SDRAM controller: round-robin access arbitration
// plus a periodic auto-refresh timer, one operation handed over at a time.
module sdr_access_sched
  import sdr_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 24,
  parameter int REF_PERIOD = DEFAULT_REF_PERIOD
) (
  input  logic                        pclk,
  input  logic                        preset,
  input  logic                        init_done,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        ctrl_start,
  output logic                        ctrl_write,
  output logic [ADDR_W-1:0]           ctrl_addr,
  output logic                        ref_req,
  input  logic                        ref_ack,
  input  logic                        ctrl_cyc_end,
  output logic                        ref_overflow
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(REF_PERIOD);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(REF_PERIOD - 1);
  localparam logic [IDX_W-1:0] PTR_RESET  = IDX_W'(NUM_REQ - 1);

  sched_state_t     state;
  logic [TMR_W-1:0] ref_timer;
  logic             ref_pending;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic             expire;
  logic             ref_clear;

  sdr_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (req),
    .ptr    (rr_ptr),
    .winner (win_idx),
    .valid  (win_valid)
  );

  assign expire    = init_done && (ref_timer == '0);
  assign ref_clear = (state == S_REF_REQ) && ref_ack;

  // A fresh expiry always wins over an ack in the same cycle, so the owed
  // refresh is re-armed rather than lost; overflow only when one is truly stacked.
  always_ff @(posedge pclk) begin
    if (preset) begin
      ref_timer    <= TMR_RELOAD;
      ref_pending  <= 1'b0;
      ref_overflow <= 1'b0;
    end else begin
      if (init_done) begin
        ref_timer <= expire ? TMR_RELOAD : ref_timer - TMR_W'(1);
      end
      if (expire) begin
        ref_pending <= 1'b1;
        if (ref_pending && !ref_clear) begin
          ref_overflow <= 1'b1;
        end
      end else if (ref_clear) begin
        ref_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state      <= S_IDLE;
      gnt        <= '0;
      grant_id   <= '0;
      ctrl_start <= 1'b0;
      ctrl_write <= 1'b0;
      ctrl_addr  <= '0;
      ref_req    <= 1'b0;
      rr_ptr     <= PTR_RESET;
    end else begin
      gnt        <= '0;
      ctrl_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (init_done) begin
            if (ref_pending) begin
              ref_req <= 1'b1;
              state   <= S_REF_REQ;
            end else if (win_valid) begin
              gnt[win_idx] <= 1'b1;
              ctrl_start   <= 1'b1;
              grant_id     <= win_idx;
              ctrl_write   <= req_write[win_idx];
              ctrl_addr    <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
              state        <= S_ACC_START;
            end
          end
        end
        S_REF_REQ: begin
          if (ref_ack) begin
            ref_req <= 1'b0;
            state   <= S_REF_WAIT;
          end
        end
        S_REF_WAIT: begin
          if (ctrl_cyc_end) begin
            state <= S_IDLE;
          end
        end
        S_ACC_START: begin
          state <= S_ACC_WAIT;
        end
        S_ACC_WAIT: begin
          // The pointer only moves once the access is finished.
          if (ctrl_cyc_end) begin
            rr_ptr <= grant_id;
            state  <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sdr_access_sched.md
# sdr_access_sched

Front-end scheduler for the SDRAM command controller. It arbitrates up to NUM_REQ requesters round-robin and generates periodic auto-refresh requests, so the controller sees one access or one refresh at a time. Refresh has priority over pending accesses. Sits between the bus-side requesters and the controller's request, refresh-handshake and cycle-end signals.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 24, access address width
- REF_PERIOD, 780, clocks between refresh requests (≥ 2)
- pclk  in  1  clock
- preset  in  1  reset; synchronous, active-high
- init_done  in  1  controller init sequence complete
- req  in  NUM_REQ  per-requester access request; held until its gnt
- req_write  in  NUM_REQ  per-requester direction (1 = write)
- req_addr  in  NUM_REQ*ADDR_W  per-requester address; slice i = bits [i*ADDR_W +: ADDR_W]
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse
- grant_id  out  $clog2(NUM_REQ)  index of the current/last grantee
- ctrl_start  out  1  one-cycle access start to controller
- ctrl_write  out  1  latched direction, valid from ctrl_start through cycle end
- ctrl_addr  out  ADDR_W  latched address, same validity
- ref_req  out  1  refresh request, level
- ref_ack  in  1  controller accepted refresh
- ctrl_cyc_end  in  1  one-cycle pulse: access or refresh finished
- ref_overflow  out  1  sticky: a refresh interval expired while the previous refresh was still pending

## Operation
- States: S_IDLE, S_REF_REQ, S_REF_WAIT, S_ACC_START, S_ACC_WAIT.
- S_IDLE: stays while init_done = 0. Otherwise, if ref_pending → S_REF_REQ with ref_req = 1. Else, if any req bit is set → select a winner, latch its write/address, pulse gnt[w] and ctrl_start, and go to S_ACC_START.
- S_REF_REQ: ref_req is held until ref_ack. On ref_ack, clear ref_pending, drop ref_req, and go to S_REF_WAIT.
- S_REF_WAIT: on ctrl_cyc_end → S_IDLE.
- S_ACC_START: one cycle. gnt and ctrl_start return to 0, then → S_ACC_WAIT. ctrl_cyc_end is ignored in this state.
- S_ACC_WAIT: on ctrl_cyc_end → S_IDLE. The round-robin pointer is updated to the winner.
- Round-robin: search starts at pointer+1 mod NUM_REQ, first set bit wins. The pointer resets to NUM_REQ-1, so req[0] has first priority.
- Refresh timer:
  - Counts down from REF_PERIOD-1 only while init_done = 1. It runs in every state.
  - At 0 it reloads and sets ref_pending.
  - If ref_pending is already set at expiry, ref_overflow is set and stays set until reset. Only one refresh is owed.
- ctrl_write/ctrl_addr hold their value until the next grant.

## Timing
- Reset values: state S_IDLE, gnt 0, grant_id 0, ctrl_start 0, ctrl_write 0, ctrl_addr 0, ref_req 0, ref_overflow 0, ref_pending 0, timer REF_PERIOD-1, pointer NUM_REQ-1.
- All outputs are registered.
- Grant latency: req seen in S_IDLE at cycle N → gnt/ctrl_start high in cycle N+1 only. Address and direction are valid from N+1.
- Back-to-back: ctrl_cyc_end at cycle M → S_IDLE at M+1 → earliest next gnt at M+2.
- Refresh latency: ref_pending set at cycle N while in S_IDLE → ref_req high at N+1.
- Simultaneous events:
  - Timer expiry in the same cycle S_IDLE grants an access: the access wins, and the refresh is issued after its cyc_end.
  - ref_ack in the same cycle as a new expiry: the new expiry re-sets ref_pending, and no overflow is flagged.
- init_done falling: if not in S_IDLE, the current operation completes. The scheduler then holds in S_IDLE and the timer freezes.
- Reset mid-operation: all outputs return to reset values on the next edge. The latched request is discarded, and requesters re-request.

## Structure
- Package sdr_sched_pkg holds sched_state_t (the five states) and the default REF_PERIOD constant.
- Sub-module sdr_rr_arbiter is combinational: inputs req vector and pointer; outputs winner index and valid. Parameterised by NUM_REQ.
- The refresh timer and FSM stay in sdr_access_sched.

## Test plan
Bench parameters: NUM_REQ = 4, REF_PERIOD = 16, ADDR_W = 24.
- After reset with init_done = 0: req = 4'b0001 → no gnt and no ref_req for 40 cycles; all outputs 0.
- init_done = 1 at cycle 0, req[2] = 1, addr 0x00ABCD, write = 1 → gnt = 4'b0100 and ctrl_start at cycle 2; ctrl_addr = 0x00ABCD, ctrl_write = 1. After cyc_end, the next gnt comes no earlier than 2 cycles later.
- req = 4'b1111 held, cyc_end returned 3 cycles after every start → grant order 0, 1, 2, 3, 0; no requester is granted twice in a row while others wait.
- Refresh: no req, ref_ack held off → ref_req rises 16 cycles after init_done and stays high. Ack at cycle 20 → ref_req falls at 21. Withholding ack for more than 16 further cycles sets ref_overflow = 1 permanently.
- Expiry in the same cycle a grant is made → that access completes first, then ref_req asserts the cycle after S_IDLE is re-entered.
- Assert preset during S_ACC_WAIT → next cycle all outputs are 0 and state is S_IDLE. A subsequent req[3] alone is granted normally.
